// File: rtl/encap_pkg.sv
// Shared definitions for the encap_head header-insertion stage:
// tag field positions, slice geometry, FSM states and the FIFO entry layout.
package encap_pkg;

    localparam int HEAD_W      = 512;
    localparam int META_W      = 256;
    localparam int TAG_W       = 16;
    localparam int INS_BYTES   = 32;
    localparam int SLICE_BYTES = HEAD_W / 8;

    // Tag bit positions (tag sits above the data bits)
    localparam int TAG_VALID   = 0;
    localparam int TAG_START   = 1;
    localparam int TAG_TAIL    = 2;
    localparam int TAG_TB_LO   = 3;
    localparam int TAG_TB_HI   = 9;
    localparam int TB_W        = TAG_TB_HI - TAG_TB_LO + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BODY  = 2'd1,
        ST_EXTRA = 2'd2
    } state_t;

    // One buffered input slice with the packet context sampled alongside it
    typedef struct packed {
        logic [HEAD_W+TAG_W-1:0] head;
        logic [META_W+TAG_W-1:0] meta;
        logic [5:0]              ins_len;
        logic [INS_BYTES*8-1:0]  ins_data;
    } fifo_entry_t;

    // Insert length is limited to the width of the insert data bus
    function automatic logic [5:0] clamp_len(input logic [5:0] n);
        return (n > 6'(INS_BYTES)) ? 6'(INS_BYTES) : n;
    endfunction

endpackage

// File: rtl/encap_fifo.sv
// Synchronous FIFO with full/empty flags. Pointers carry one wrap bit so
// full and empty are distinguishable. Push while full is only honoured
// when a pop happens in the same cycle (caller gates i_push accordingly).
module encap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_data  = mem[rd_ptr[AW-1:0]];

    // Pointer advance on accepted push / pop
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (i_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (i_pop && !o_empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate them
    always_ff @(posedge i_clk) begin
        if (i_push)
            mem[wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/encap_head.sv
// Header-insertion stage: prepends up to INS_MAX_BYTES bytes to each packet,
// re-aligns the following slices and emits an extra tail slice when the
// insertion spills past the last slice. Byte 0 is at the data MSB.
// Optional: define ENCAP_STATS_EN to enable the packet/drop counters;
// otherwise o_pktCnt and o_dropCnt are tied to 0.
module encap_head
    import encap_pkg::*;
#(
    parameter int HEAD_WIDTH    = 512,
    parameter int META_WIDTH    = 256,
    parameter int TAG_WIDTH     = 16,
    parameter int INS_MAX_BYTES = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [HEAD_WIDTH+TAG_WIDTH-1:0] i_head,
    input  logic [META_WIDTH+TAG_WIDTH-1:0] i_meta,
    input  logic [5:0]                      i_insLen,
    input  logic [INS_MAX_BYTES*8-1:0]      i_insData,
    output logic [HEAD_WIDTH+TAG_WIDTH-1:0] o_head,
    output logic [META_WIDTH+TAG_WIDTH-1:0] o_meta,
    output logic                            o_busy,
    output logic                            o_err,
    output logic [31:0]                     o_pktCnt,
    output logic [31:0]                     o_dropCnt
);

    localparam int ENTRY_W = $bits(fifo_entry_t);
    localparam int INS_W   = INS_MAX_BYTES * 8;

    fifo_entry_t                     wr_entry;
    fifo_entry_t                     rd_entry;
    logic [ENTRY_W-1:0]              rd_flat;
    logic                            push, pop, full, empty, overflow;

    state_t                          state, state_nxt;
    logic [HEAD_WIDTH-1:0]           carry_r;
    logic [5:0]                      len_r;
    logic [TAG_WIDTH-1:0]            tag_r;
    logic [TB_W-1:0]                 rem_r;
    logic                            err_r;

    logic [TAG_WIDTH-1:0]            rd_tag;
    logic [HEAD_WIDTH-1:0]           rd_data;
    logic                            rd_start, rd_tail, begin_pkt;
    logic [5:0]                      cur_len;
    logic [9:0]                      shift;
    logic [HEAD_WIDTH-1:0]           ins_ext, ins_mask, pre, body_data, carry_nxt;
    logic [7:0]                      tb_sum;

    logic                            out_vld;
    logic [HEAD_WIDTH-1:0]           out_data;
    logic [TAG_WIDTH-1:0]            out_tag;
    logic [META_WIDTH+TAG_WIDTH-1:0] out_meta;
    logic                            carry_ld, len_ld, extra_ld, pkt_inc, orphan, abort;
    logic [1:0]                      drop_n;

    logic [HEAD_WIDTH+TAG_WIDTH-1:0] head_p1;
    logic [META_WIDTH+TAG_WIDTH-1:0] meta_p1;

    // Input side: every valid slice is buffered with its packet context
    assign push     = i_head[HEAD_WIDTH+TAG_VALID];
    assign wr_entry = '{head: i_head, meta: i_meta, ins_len: clamp_len(i_insLen), ins_data: i_insData};
    assign overflow = push && full && !pop;
    assign pop      = (state != ST_EXTRA) && !empty;

    encap_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push && (!full || pop)),
        .i_data  (wr_entry),
        .i_pop   (pop),
        .o_data  (rd_flat),
        .o_full  (full),
        .o_empty (empty)
    );

    assign rd_entry  = rd_flat;
    assign rd_tag    = rd_entry.head[HEAD_WIDTH +: TAG_WIDTH];
    assign rd_data   = rd_entry.head[HEAD_WIDTH-1:0];
    assign rd_start  = rd_tag[TAG_START];
    assign rd_tail   = rd_tag[TAG_TAIL];
    assign begin_pkt = pop && rd_start;

    // Alignment: the leading bytes come from the insert bus on a start slice
    // and from the previous slice's leftover (top-aligned carry) otherwise.
    assign cur_len   = begin_pkt ? rd_entry.ins_len : len_r;
    assign shift     = {1'b0, cur_len, 3'b000};
    assign ins_ext   = {rd_entry.ins_data, {(HEAD_WIDTH-INS_W){1'b0}}};
    assign ins_mask  = ~({HEAD_WIDTH{1'b1}} >> shift);
    assign pre       = begin_pkt ? (ins_ext & ins_mask) : carry_r;
    assign body_data = pre | (rd_data >> shift);
    assign carry_nxt = rd_data << (10'(HEAD_WIDTH) - shift);
    assign tb_sum    = 8'(rd_tag[TAG_TB_HI:TAG_TB_LO]) + 8'(cur_len);
    assign drop_n    = {1'b0, overflow} + {1'b0, orphan};

    // FSM next state and output slice assembly
    always_comb begin
        state_nxt = state;
        out_vld   = 1'b0;
        out_data  = body_data;
        out_tag   = rd_tag;
        out_meta  = '0;
        carry_ld  = 1'b0;
        len_ld    = 1'b0;
        extra_ld  = 1'b0;
        pkt_inc   = 1'b0;
        orphan    = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_EXTRA: begin
                out_vld                       = 1'b1;
                out_data                      = carry_r;
                out_tag                       = tag_r;
                out_tag[TAG_START]            = 1'b0;
                out_tag[TAG_TAIL]             = 1'b1;
                out_tag[TAG_TB_HI:TAG_TB_LO]  = rem_r;
                pkt_inc                       = 1'b1;
                state_nxt                     = ST_IDLE;
            end
            default: begin
                if (pop) begin
                    if (!rd_start && state == ST_IDLE) begin
                        orphan = 1'b1;
                    end else begin
                        abort     = rd_start && (state == ST_BODY);
                        out_vld   = 1'b1;
                        carry_ld  = 1'b1;
                        len_ld    = rd_start;
                        state_nxt = ST_BODY;
                        if (rd_start)
                            out_meta = rd_entry.meta;
                        if (rd_tail) begin
                            if (tb_sum <= 8'(SLICE_BYTES)) begin
                                out_tag[TAG_TB_HI:TAG_TB_LO] = tb_sum[TB_W-1:0];
                                pkt_inc   = 1'b1;
                                state_nxt = ST_IDLE;
                            end else begin
                                out_tag[TAG_TAIL]            = 1'b0;
                                out_tag[TAG_TB_HI:TAG_TB_LO] = '0;
                                extra_ld  = 1'b1;
                                state_nxt = ST_EXTRA;
                            end
                        end
                    end
                end
            end
        endcase
        out_tag[TAG_VALID] = out_vld;
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Packet context: carry bytes, insert length, spill tag and remainder
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            carry_r <= '0;
            len_r   <= '0;
            tag_r   <= '0;
            rem_r   <= '0;
        end else begin
            if (carry_ld)
                carry_r <= carry_nxt;
            if (len_ld)
                len_r <= rd_entry.ins_len;
            if (extra_ld) begin
                tag_r <= rd_tag;
                rem_r <= TB_W'(tb_sum - 8'(SLICE_BYTES));
            end
        end
    end

    // ---- output stage (p1) ----
    // Registered output slice and meta; idle cycles drive all zeros
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head_p1 <= '0;
            meta_p1 <= '0;
        end else begin
            head_p1 <= out_vld ? {out_tag, out_data} : '0;
            meta_p1 <= out_meta;
        end
    end

    // Sticky error: overflow, orphan slice or aborted packet
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            err_r <= 1'b0;
        else if (overflow || orphan || abort)
            err_r <= 1'b1;
    end

    assign o_head = head_p1;
    assign o_meta = meta_p1;
    assign o_err  = err_r;
    assign o_busy = !empty || (state != ST_IDLE);

`ifdef ENCAP_STATS_EN
    logic [31:0] pkt_cnt;
    logic [31:0] drop_cnt;

    // Wrapping statistics counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            pkt_cnt  <= pkt_cnt + 32'(pkt_inc);
            drop_cnt <= drop_cnt + 32'(drop_n);
        end
    end

    assign o_pktCnt  = pkt_cnt;
    assign o_dropCnt = drop_cnt;
`else
    logic unused_stats;
    assign unused_stats = ^{pkt_inc, drop_n};
    assign o_pktCnt     = '0;
    assign o_dropCnt    = '0;
`endif

endmodule

// File: tb/tb_encap_head.sv
// Directed bench for encap_head: expected slices come from a byte-stream
// model (insert bytes followed by packet bytes, re-chunked into 64 B slices).
module tb_encap_head;

    localparam int HW = 512;
    localparam int MW = 256;
    localparam int TW = 16;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [HW+TW-1:0]  i_head;
    logic [MW+TW-1:0]  i_meta;
    logic [5:0]        i_insLen;
    logic [255:0]      i_insData;
    logic [HW+TW-1:0]  o_head;
    logic [MW+TW-1:0]  o_meta;
    logic              o_busy;
    logic              o_err;
    logic [31:0]       o_pktCnt;
    logic [31:0]       o_dropCnt;

    encap_head #(
        .HEAD_WIDTH(HW), .META_WIDTH(MW), .TAG_WIDTH(TW),
        .INS_MAX_BYTES(32), .FIFO_DEPTH(4)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_head(i_head), .i_meta(i_meta),
        .i_insLen(i_insLen), .i_insData(i_insData), .o_head(o_head),
        .o_meta(o_meta), .o_busy(o_busy), .o_err(o_err),
        .o_pktCnt(o_pktCnt), .o_dropCnt(o_dropCnt)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Output capture, sampled on the falling edge
    logic [HW-1:0] q_data [$];
    logic [TW-1:0] q_tag  [$];
    logic [TW-1:0] q_mtag [$];
    int            q_cyc  [$];

    always @(negedge i_clk) begin
        if (o_head[HW] === 1'b1) begin
            q_data.push_back(o_head[HW-1:0]);
            q_tag.push_back(o_head[HW +: TW]);
            q_mtag.push_back(o_meta[MW +: TW]);
            q_cyc.push_back(cyc);
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    function automatic logic [HW-1:0] rnd512();
        logic [HW-1:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [TW-1:0] tagf(input bit st, input bit tl, input int tb);
        logic [TW-1:0] t;
        t    = 16'h0001;
        t[1] = st;
        t[2] = tl;
        if (tl) t[9:3] = tb[6:0];
        return t;
    endfunction

    function automatic logic [HW-1:0] get_d(input int i);
        return (i < q_data.size()) ? q_data[i] : 'x;
    endfunction

    function automatic logic [TW-1:0] get_t(input int i);
        return (i < q_tag.size()) ? q_tag[i] : 'x;
    endfunction

    function automatic int get_c(input int i);
        return (i < q_cyc.size()) ? q_cyc[i] : -1000;
    endfunction

    task automatic clear_q();
        q_data.delete(); q_tag.delete(); q_mtag.delete(); q_cyc.delete();
    endtask

    task automatic drive(input logic [TW-1:0] tag, input logic [HW-1:0] d, input logic [5:0] len,
                         input logic [255:0] ins, input logic [TW-1:0] mtag);
        @(posedge i_clk); #1;
        i_head    = {tag, d};
        i_meta    = {mtag, {8{32'hCAFEF00D}}};
        i_insLen  = len;
        i_insData = ins;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk); #1;
            i_head = '0;
            i_meta = '0;
        end
    endtask

    // Reference model state
    logic [HW-1:0]  in_sl  [8];
    logic [HW-1:0]  exp_sl [10];
    logic [255:0]   ins_m;
    int             exp_n;
    int             exp_tb;

    task automatic model(input int n, input int tb, input int L);
        logic [7:0] st [$];
        int total;
        st.delete();
        for (int i = 0; i < L; i++) st.push_back(ins_m[255-8*i -: 8]);
        for (int k = 0; k < n; k++)
            for (int b = 0; b < ((k == n-1) ? tb : 64); b++)
                st.push_back(in_sl[k][HW-1-8*b -: 8]);
        total  = st.size();
        exp_n  = (total + 63) / 64;
        exp_tb = total - 64 * (exp_n - 1);
        for (int s = 0; s < exp_n; s++) begin
            exp_sl[s] = '0;
            for (int b = 0; b < 64; b++)
                if (64*s + b < total) exp_sl[s][HW-1-8*b -: 8] = st[64*s + b];
        end
    endtask

    task automatic check_out(input string nm, input int base, input int in_cyc, input int lat);
        logic [HW-1:0] mask;
        int vb;
        for (int s = 0; s < exp_n; s++) begin
            vb   = (s == exp_n-1) ? exp_tb : 64;
            mask = ~({HW{1'b1}} >> (8*vb));
            chkw($sformatf("%s_data%0d", nm, s), get_d(base+s) & mask, exp_sl[s] & mask);
            chk($sformatf("%s_tag%0d", nm, s), 64'(get_t(base+s)),
                64'(tagf(s == 0, s == exp_n-1, exp_tb)));
        end
        chk($sformatf("%s_latency", nm), 64'(get_c(base) - in_cyc), 64'(lat));
    endtask

    logic [HW-1:0]  pd [5];
    logic [255:0]   pi [5];
    int             pc [5];
    int             c0;
    logic [31:0]    exp_drop, exp_pkt8, exp_pkt1;

    initial begin
`ifdef ENCAP_STATS_EN
        exp_drop = 32'd1; exp_pkt8 = 32'd8; exp_pkt1 = 32'd1;
`else
        exp_drop = 32'd0; exp_pkt8 = 32'd0; exp_pkt1 = 32'd0;
`endif
        i_rst = 1'b1; i_head = '0; i_meta = '0; i_insLen = '0; i_insData = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_head", 64'(|o_head), 64'd0);
        chk("rst_meta", 64'(|o_meta), 64'd0);
        chk("rst_err",  64'(o_err), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_pkt",  64'(o_pktCnt), 64'd0);
        chk("rst_drop", 64'(o_dropCnt), 64'd0);
        i_rst = 1'b0;

        // 1-slice packet, TAILBYTES=20, L=8
        clear_q();
        in_sl[0] = rnd512(); ins_m = rnd256();
        drive(tagf(1, 1, 20), in_sl[0], 6'd8, ins_m, 16'h00A7);
        c0 = cyc;
        idle(6);
        chk("t1_count", 64'(q_data.size()), 64'd1);
        model(1, 20, 8);
        chk("t1_model_tb", 64'(exp_tb), 64'd28);
        check_out("t1", 0, c0, 2);
        chk("t1_meta_tag", 64'((q_mtag.size() > 0) ? q_mtag[0] : 16'hxxxx), 64'h00A7);

        // 3-slice packet, tail TAILBYTES=60, L=16 -> spill slice
        clear_q();
        for (int k = 0; k < 3; k++) in_sl[k] = rnd512();
        ins_m = rnd256();
        drive(tagf(1, 0, 0),  in_sl[0], 6'd16, ins_m, 16'h0033);
        c0 = cyc;
        drive(tagf(0, 0, 0),  in_sl[1], 6'd0, '0, 16'h0);
        drive(tagf(0, 1, 60), in_sl[2], 6'd0, '0, 16'h0);
        idle(8);
        chk("t2_count", 64'(q_data.size()), 64'd4);
        model(3, 60, 16);
        chk("t2_model_tb", 64'(exp_tb), 64'd12);
        check_out("t2", 0, c0, 2);
        chk("t2_meta_nonstart", 64'((q_mtag.size() > 1) ? q_mtag[1] : 16'hxxxx), 64'd0);

        // Five gapless 1-slice packets, TAILBYTES=64, L=1
        clear_q();
        for (int p = 0; p < 5; p++) begin
            pd[p] = rnd512(); pi[p] = rnd256();
            drive(tagf(1, 1, 64), pd[p], 6'd1, pi[p], 16'(16 + p));
            pc[p] = cyc;
        end
        idle(16);
        chk("t3_count", 64'(q_data.size()), 64'd10);
        chk("t3_err", 64'(o_err), 64'd0);
        chk("t3_drop", 64'(o_dropCnt), 64'd0);
        for (int p = 0; p < 5; p++) begin
            in_sl[0] = pd[p]; ins_m = pi[p];
            model(1, 64, 1);
            check_out($sformatf("t3_pkt%0d", p), 2*p, pc[p], 2 + p);
        end

        // L=0: bit-exact passthrough of a 5-slice packet
        clear_q();
        for (int k = 0; k < 5; k++) in_sl[k] = rnd512();
        for (int k = 0; k < 5; k++) begin
            drive(tagf(k == 0, k == 4, 37), in_sl[k], 6'd0, rnd256(), 16'h0055);
            if (k == 0) c0 = cyc;
        end
        idle(8);
        chk("t4_count", 64'(q_data.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            chkw($sformatf("t4_data%0d", k), get_d(k), in_sl[k]);
            chk($sformatf("t4_tag%0d", k), 64'(get_t(k)), 64'(tagf(k == 0, k == 4, 37)));
            chk($sformatf("t4_lat%0d", k), 64'(get_c(k) - (c0 + k)), 64'd2);
        end
        chk("t4_pktcnt", 64'(o_pktCnt), 64'(exp_pkt8));
        chk("t4_err", 64'(o_err), 64'd0);

        // Orphan slice in IDLE
        clear_q();
        drive(tagf(0, 0, 0), rnd512(), 6'd0, '0, 16'h0);
        idle(5);
        chk("t5_count", 64'(q_data.size()), 64'd0);
        chk("t5_err", 64'(o_err), 64'd1);
        chk("t5_drop", 64'(o_dropCnt), 64'(exp_drop));

        // Reset while the second output slice is on the bus
        clear_q();
        for (int k = 0; k < 3; k++) in_sl[k] = rnd512();
        drive(tagf(1, 0, 0),  in_sl[0], 6'd4, rnd256(), 16'h0009);
        drive(tagf(0, 0, 0),  in_sl[1], 6'd0, '0, 16'h0);
        drive(tagf(0, 1, 50), in_sl[2], 6'd0, '0, 16'h0);
        @(posedge i_clk); #3;
        chk("t6_vld_before", 64'(o_head[HW]), 64'd1);
        i_head = '0; i_meta = '0;
        i_rst  = 1'b1;
        #1;
        chk("t6_head_zero", 64'(|o_head), 64'd0);
        chk("t6_err_clr",   64'(o_err), 64'd0);
        chk("t6_busy_clr",  64'(o_busy), 64'd0);
        chk("t6_drop_clr",  64'(o_dropCnt), 64'd0);
        @(posedge i_clk); @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        chk("t6_vld_after", 64'(o_head[HW]), 64'd0);

        // Clean packet after reset, oversized insLen=40 clamps to 32
        clear_q();
        in_sl[0] = rnd512(); in_sl[1] = rnd512(); ins_m = rnd256();
        drive(tagf(1, 0, 0),  in_sl[0], 6'd40, ins_m, 16'h0077);
        c0 = cyc;
        drive(tagf(0, 1, 64), in_sl[1], 6'd0, '0, 16'h0);
        idle(8);
        chk("t7_count", 64'(q_data.size()), 64'd3);
        model(2, 64, 32);
        check_out("t7", 0, c0, 2);
        chk("t7_pktcnt", 64'(o_pktCnt), 64'(exp_pkt1));
        chk("t7_err", 64'(o_err), 64'd0);
        chk("t7_busy", 64'(o_busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
